// File: rtl/contact_entry_if.sv
// ============================================================================
// contact_entry_if : keypad / call-controller signal bundle for contact_entry
// Revision 1.0
// ============================================================================
`default_nettype none

interface contact_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        cancel;
  logic        fsm_busy;
  logic        dial;
  logic        valid_cntct;
  logic [15:0] number;
  logic [2:0]  digit_count;
  logic        entry_err;
  logic        reject;

  modport master (
    output key_valid, key_code, cancel, fsm_busy,
    input  dial, valid_cntct, number, digit_count, entry_err, reject
  );

  modport slave (
    input  key_valid, key_code, cancel, fsm_busy,
    output dial, valid_cntct, number, digit_count, entry_err, reject
  );
endinterface

`default_nettype wire

// File: rtl/contact_entry.sv
// ============================================================================
// contact_entry : 4-digit BCD keypad entry, contact match and dial handshake
// Revision 1.0
// ============================================================================
`default_nettype none

module contact_entry #(
  parameter logic [15:0] CONTACT0    = 16'h1234,
  parameter logic [15:0] CONTACT1    = 16'h5678,
  parameter logic [15:0] CONTACT2    = 16'h9012,
  parameter logic [15:0] CONTACT3    = 16'h0911,
  parameter int          REQ_TIMEOUT = 15
) (
  input  wire logic       clk,
  input  wire logic       reset,
  contact_entry_if.slave  bus
);

  localparam int CNT_W = (REQ_TIMEOUT < 2) ? 1 : $clog2(REQ_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REQ_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_CHECK   = 2'd1,
    ST_REQUEST = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      number_q, number_d;
  logic [2:0]       count_q, count_d;
  logic             dial_q, dial_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             reject_q, reject_d;
  logic [CNT_W-1:0] req_cnt_q, req_cnt_d;

  logic match;
  assign match = (number_q == CONTACT0) || (number_q == CONTACT1) ||
                 (number_q == CONTACT2) || (number_q == CONTACT3);

  always_comb begin
    state_d   = state_q;
    number_d  = number_q;
    count_d   = count_q;
    dial_d    = dial_q;
    valid_d   = valid_q;
    err_d     = 1'b0;
    reject_d  = 1'b0;
    req_cnt_d = req_cnt_q;

    if (bus.cancel) begin
      state_d   = ST_ENTRY;
      number_d  = 16'h0000;
      count_d   = 3'd0;
      dial_d    = 1'b0;
      valid_d   = 1'b0;
      req_cnt_d = '0;
    end else begin
      case (state_q)
        ST_ENTRY: begin
          if (bus.key_valid) begin
            if (bus.key_code <= 4'd9) begin
              if (count_q != 3'd4) begin
                number_d = {number_q[11:0], bus.key_code};
                count_d  = count_q + 3'd1;
              end else begin
                err_d = 1'b1;
              end
            end else if (bus.key_code == 4'hA) begin
              if (count_q != 3'd0) begin
                number_d = {4'h0, number_q[15:4]};
                count_d  = count_q - 3'd1;
              end
            end else if (bus.key_code == 4'hB) begin
              if (count_q == 3'd4) state_d = ST_CHECK;
              else                 err_d   = 1'b1;
            end else if (bus.key_code == 4'hC) begin
              number_d = 16'h0000;
              count_d  = 3'd0;
            end
          end
        end

        ST_CHECK: begin
          if (match) begin
            state_d   = ST_REQUEST;
            dial_d    = 1'b1;
            valid_d   = 1'b1;
            req_cnt_d = '0;
          end else begin
            state_d  = ST_ENTRY;
            reject_d = 1'b1;
            number_d = 16'h0000;
            count_d  = 3'd0;
          end
        end

        ST_REQUEST: begin
          // Busy wins over a timeout landing in the same cycle.
          if (bus.fsm_busy) begin
            state_d = ST_LOCKED;
            dial_d  = 1'b0;
            valid_d = 1'b0;
          end else if (req_cnt_q == CNT_LAST) begin
            state_d   = ST_ENTRY;
            err_d     = 1'b1;
            dial_d    = 1'b0;
            valid_d   = 1'b0;
            number_d  = 16'h0000;
            count_d   = 3'd0;
            req_cnt_d = '0;
          end else begin
            req_cnt_d = req_cnt_q + CNT_W'(1);
          end
        end

        ST_LOCKED: begin
          dial_d  = 1'b0;
          valid_d = 1'b0;
          if (!bus.fsm_busy) begin
            state_d  = ST_ENTRY;
            number_d = 16'h0000;
            count_d  = 3'd0;
          end
        end

        default: begin
          state_d  = ST_ENTRY;
          number_d = 16'h0000;
          count_d  = 3'd0;
          dial_d   = 1'b0;
          valid_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ENTRY;
      number_q  <= 16'h0000;
      count_q   <= 3'd0;
      dial_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      reject_q  <= 1'b0;
      req_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      number_q  <= number_d;
      count_q   <= count_d;
      dial_q    <= dial_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      reject_q  <= reject_d;
      req_cnt_q <= req_cnt_d;
    end
  end

  assign bus.dial        = dial_q;
  assign bus.valid_cntct = valid_q;
  assign bus.number      = number_q;
  assign bus.digit_count = count_q;
  assign bus.entry_err   = err_q;
  assign bus.reject      = reject_q;

endmodule

`default_nettype wire

// File: tb/tb_contact_entry.sv
// ============================================================================
// tb_contact_entry : scoreboard bench for contact_entry
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_contact_entry;

  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_ERR  = 2;
  localparam int K_REJ  = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] num;
    logic [2:0]  dc;
    logic        vc;
  } ev_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   ke;
  ev_t  exp_q[$];

  contact_entry_if bus ();

  contact_entry dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_ev(input int kind, input int c, input logic [15:0] n,
                           input logic [2:0] d, input logic v);
    exp_q.push_back('{kind, c, n, d, v});
  endtask

  task automatic observe(input int kind);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d num=%h dc=%0d (required: no event)",
               kind, cyc, bus.number, bus.digit_count);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || bus.number !== e.num ||
          bus.digit_count !== e.dc || bus.valid_cntct !== e.vc) begin
        n_fail++;
        $display("FAIL event got kind=%0d cyc=%0d num=%h dc=%0d vc=%b required kind=%0d cyc=%0d num=%h dc=%0d vc=%b",
                 kind, cyc, bus.number, bus.digit_count, bus.valid_cntct,
                 e.kind, e.cyc, e.num, e.dc, e.vc);
      end
    end
  endtask

  // Samples just after the falling edge so stimulus pushed on that edge is already queued.
  initial begin
    logic prev_dial;
    prev_dial = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.dial !== prev_dial) begin
        observe(bus.dial ? K_RISE : K_FALL);
        prev_dial = bus.dial;
      end
      if (bus.entry_err === 1'b1) observe(K_ERR);
      if (bus.reject === 1'b1)    observe(K_REJ);
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask

  task automatic drive(input logic kv, input logic [3:0] code, input logic cn);
    @(negedge clk);
    bus.key_valid = kv;
    bus.key_code  = code;
    bus.cancel    = cn;
    @(negedge clk);
    ke = cyc;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.cancel    = 1'b0;
  endtask

  task automatic key(input logic [3:0] code);
    drive(1'b1, code, 1'b0);
  endtask

  task automatic keys4(input logic [15:0] n);
    for (int i = 3; i >= 0; i--) key(n[i*4 +: 4]);
  endtask

  initial begin
    reset         = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.cancel    = 1'b0;
    bus.fsm_busy  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_number", bus.number, 16'h0000);
    check("rst_count",  16'(bus.digit_count), 16'd0);
    check("rst_flags",  {12'h0, bus.dial, bus.valid_cntct, bus.entry_err, bus.reject}, 16'h0000);
    reset = 1'b0;

    // Valid contact, controller takes it, then returns to idle
    keys4(16'h1234);
    check("entry_number", bus.number, 16'h1234);
    check("entry_count",  16'(bus.digit_count), 16'd4);
    key(4'hB);
    expect_ev(K_RISE, ke + 1, 16'h1234, 3'd4, 1'b1);
    @(negedge clk);
    bus.fsm_busy = 1'b1;
    expect_ev(K_FALL, ke + 2, 16'h1234, 3'd4, 1'b0);
    repeat (3) @(negedge clk);
    check("locked_hold", bus.number, 16'h1234);
    bus.fsm_busy = 1'b0;
    @(negedge clk);
    check("unlock_count",  16'(bus.digit_count), 16'd0);
    check("unlock_number", bus.number, 16'h0000);

    // Unknown number is rejected
    keys4(16'h5555);
    key(4'hB);
    expect_ev(K_REJ, ke + 1, 16'h0000, 3'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("reject_count", 16'(bus.digit_count), 16'd0);

    // Early dial, overflow digit, backspace, ignored code, clear
    key(4'h1);
    key(4'h2);
    key(4'hB);
    expect_ev(K_ERR, ke, 16'h0012, 3'd2, 1'b0);
    key(4'h3);
    key(4'h4);
    key(4'h5);
    expect_ev(K_ERR, ke, 16'h1234, 3'd4, 1'b0);
    check("overflow_number", bus.number, 16'h1234);
    key(4'hA);
    check("bksp_number", bus.number, 16'h0123);
    check("bksp_count",  16'(bus.digit_count), 16'd3);
    key(4'hD);
    check("ignored_number", bus.number, 16'h0123);
    key(4'hC);
    check("clear_number", bus.number, 16'h0000);
    key(4'hA);
    check("bksp_empty_count", 16'(bus.digit_count), 16'd0);

    // Request timeout with controller never busy
    keys4(16'h0911);
    key(4'hB);
    expect_ev(K_RISE, ke + 1,  16'h0911, 3'd4, 1'b1);
    expect_ev(K_FALL, ke + 16, 16'h0000, 3'd0, 1'b0);
    expect_ev(K_ERR,  ke + 16, 16'h0000, 3'd0, 1'b0);
    repeat (20) @(negedge clk);
    check("timeout_count", 16'(bus.digit_count), 16'd0);

    // Cancel together with a digit key while requesting
    keys4(16'h1234);
    key(4'hB);
    expect_ev(K_RISE, ke + 1, 16'h1234, 3'd4, 1'b1);
    expect_ev(K_FALL, ke + 2, 16'h0000, 3'd0, 1'b0);
    drive(1'b1, 4'h7, 1'b1);
    check("cancel_count", 16'(bus.digit_count), 16'd0);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-request, then first key accepted
    keys4(16'h5678);
    key(4'hB);
    expect_ev(K_RISE, ke + 1, 16'h5678, 3'd4, 1'b1);
    repeat (2) @(negedge clk);
    expect_ev(K_FALL, cyc + 1, 16'h0000, 3'd0, 1'b0);
    #2 reset = 1'b1;
    #1 check("async_rst_dial", {14'h0, bus.dial, bus.valid_cntct}, 16'h0000);
    #1 reset = 1'b0;
    key(4'h3);
    check("post_rst_key", bus.number, 16'h0003);
    key(4'hC);

    // Busy already high on entry to request, then reset while locked
    keys4(16'h1234);
    key(4'hB);
    bus.fsm_busy = 1'b1;
    expect_ev(K_RISE, ke + 1, 16'h1234, 3'd4, 1'b1);
    expect_ev(K_FALL, ke + 2, 16'h1234, 3'd4, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("locked_rst_number", bus.number, 16'h0000);
    check("locked_rst_flags",
          {10'h0, bus.digit_count, bus.dial, bus.valid_cntct, bus.entry_err}, 16'h0000);
    #1 reset = 1'b0;
    bus.fsm_busy = 1'b0;
    keys4(16'h9012);
    key(4'hB);
    expect_ev(K_RISE, ke + 1, 16'h9012, 3'd4, 1'b1);
    @(negedge clk);
    bus.fsm_busy = 1'b1;
    expect_ev(K_FALL, ke + 2, 16'h9012, 3'd4, 1'b0);
    repeat (2) @(negedge clk);
    bus.fsm_busy = 1'b0;
    repeat (3) @(negedge clk);

    check("pending_events", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
